chip_despreader: RTL
====================

// Module: chip_despreader
// PURPOSE
//   Consumes the chip stream from the CORDIC/rotation demodulator (o_dir bit qualified by o_enable_out)
//   and despreads it into 802.15.4 O-QPSK symbols. In SEARCH it slides a 32-chip window looking for the
//   symbol-0 PN sequence (preamble). Once locked, it decodes each 32-chip block to a 4-bit symbol by
//   minimum Hamming distance over the 16 PN sequences. Its output feeds the SFD/frame layer.
// PARAMETERS
//   SYNC_THRESH    4   max Hamming distance to PN0 that declares lock in SEARCH (0..32)
//   DECODE_THRESH  10  max min-distance for a valid symbol in LOCKED (0..32)
//   MAX_ERRORS     3   consecutive invalid symbols that drop lock (1..15)
// PORTS
//   clock         in   1  system clock, all logic on posedge
//   reset         in   1  asynchronous, active-high reset
//   i_enable_in   in   1  chip valid (upstream o_enable_out); single-cycle pulses, back-to-back allowed
//   i_dir         in   1  chip value, sampled only when i_enable_in=1
//   o_enable_out  out  1  one-cycle pulse: o_symbol valid
//   o_symbol      out  4  decoded symbol, held until next pulse
//   o_locked      out  1  1 while FSM is in LOCKED
// BEHAVIOUR
//   Reset: all outputs 0, shift reg 0, fill/chip/bad counters 0, state SEARCH. Takes effect immediately
//     mid-symbol; after release a full 32 fresh chips are needed before any match.
//   Window: 32-bit shift reg win; on valid chip win <= {i_dir, win[31:1]}, so the oldest chip sits in bit 0.
//     i_enable_in=0: no register changes except o_enable_out<=0.
//   PN table: PN0 = c0..c31 = 1101 1001 1100 0011 0101 0010 0010 1110 (c0 first received, stored at bit i=ci).
//     PNk[i] = PN0[(i-4k) mod 32] for k=0..7. PN(k+8)[i] = PNk[i] ^ (i odd).
//   Distance: dist_k = popcount(win_next ^ PNk) on the window including the current chip; combinational,
//     6 bits wide (0..32). Min search picks lowest index on ties.
//   FSM SEARCH: fill counter saturates at 32. On a valid chip with fill (including this chip) = 32 and
//     dist_0 <= SYNC_THRESH: -> LOCKED, chip_cnt<=0, bad_cnt<=0, emit symbol 0. Otherwise stay.
//   FSM LOCKED: chip_cnt counts valid chips 0..31 and wraps. On the valid chip with chip_cnt==31, decode:
//     min_dist <= DECODE_THRESH: emit symbol, bad_cnt<=0.
//     Otherwise: no pulse, bad_cnt++. If bad_cnt reaches MAX_ERRORS: -> SEARCH, fill<=0, bad_cnt<=0.
//   Latency: o_enable_out/o_symbol are registered, asserted the cycle after the completing i_enable_in.
//   o_locked: registered state decode; rises with the lock pulse, falls the cycle after the final bad block.
//   Simultaneous: the completing chip and the state transition occur in the same edge; the next valid
//     chip already counts as chip 0 of the new block (LOCKED) or shifts into the search window (SEARCH).
// CONFIGURATION
//   DESPREAD_DIST_EN defined: adds output port o_distance [5:0], the min_dist (or dist_0 on lock)
//     registered alongside o_symbol and updated on every decode, including invalid blocks.
//   DESPREAD_DIST_EN undefined: port and register absent; behaviour otherwise identical.
// TESTING
//   1 reset held 3 cycles, then released -> o_enable_out=0, o_symbol=0, o_locked=0.
//   2 32 chips of all-ones, then PN0 chips -> no pulse during all-ones. One cycle after the 32nd PN0 chip:
//     o_locked=1, o_enable_out pulse with o_symbol=0.
//   3 locked, then PN5 followed by PN13 (valid every 5 cycles) -> pulses with o_symbol=5, then 13;
//     o_distance=0 when DESPREAD_DIST_EN is defined.
//   4 locked, then PN9 with chips 0, 7 and 30 flipped -> o_symbol=9 (o_distance=3). With 11 chips
//     flipped -> no pulse, o_locked stays 1.
//   5 locked, then 3 blocks of all-zero chips (distance 16 to every PN) -> no pulses; o_locked=0 one cycle
//     after the 96th chip; a following PN0 relocks only after 32 new chips.
//   6 reset pulsed at chip 17 of a locked block -> outputs cleared asynchronously. Valid back-to-back
//     chips afterwards -> lock requires a fresh 32-chip PN0 window.

Source files
------------

// File: rtl/chip_despreader.sv
// 802.15.4 O-QPSK chip despreader: PN0 preamble search, then min-Hamming decode of 32-chip blocks.
// Optional `DESPREAD_DIST_EN adds the o_distance output carrying the decode distance.
module chip_despreader_corr #(
  parameter int unsigned K = 0
) (
  input  logic [31:0] i_win,
  output logic [5:0]  o_dist
);
  localparam logic [31:0] PN0 = 32'h744AC39B;
  localparam int unsigned R   = 4 * (K % 8);
  localparam logic [31:0] ROT = (R == 0) ? PN0 : ((PN0 << R) | (PN0 >> (32 - R)));
  localparam logic [31:0] PN  = (K >= 8) ? (ROT ^ 32'hAAAAAAAA) : ROT;

  logic [31:0] w_x;
  assign w_x = i_win ^ PN;

  always_comb begin
    o_dist = '0;
    for (int i = 0; i < 32; i++) o_dist = o_dist + {5'd0, w_x[i]};
  end
endmodule

module chip_despreader #(
  parameter int unsigned SYNC_THRESH   = 4,
  parameter int unsigned DECODE_THRESH = 10,
  parameter int unsigned MAX_ERRORS    = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_enable_in,
  input  logic       i_dir,
  output logic       o_enable_out,
  output logic [3:0] o_symbol,
  output logic       o_locked
`ifdef DESPREAD_DIST_EN
  ,
  output logic [5:0] o_distance
`endif
);
  localparam logic [0:0] S_SEARCH = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;
  localparam logic [5:0] SYNC_T   = 6'(SYNC_THRESH);
  localparam logic [5:0] DEC_T    = 6'(DECODE_THRESH);
  localparam logic [3:0] MAX_E    = 4'(MAX_ERRORS);

  logic [31:0]      r_win;
  logic [5:0]       r_fill;
  logic [4:0]       r_chip_cnt;
  logic [3:0]       r_bad_cnt;
  logic [0:0]       r_state;
  logic             r_enable_out;
  logic [3:0]       r_symbol;
  logic [5:0]       r_dist;

  logic [31:0]      w_win_next;
  logic [5:0]       w_fill_next;
  logic [3:0]       w_bad_next;
  logic [15:0][5:0] w_dist;
  logic [5:0]       w_min_dist;
  logic [3:0]       w_min_idx;

  assign w_win_next  = {i_dir, r_win[31:1]};
  assign w_fill_next = (r_fill == 6'd32) ? 6'd32 : r_fill + 6'd1;
  assign w_bad_next  = r_bad_cnt + 4'd1;

  // One correlator per PN sequence, all looking at the window including the current chip
  for (genvar g = 0; g < 16; g++) begin : g_corr
    chip_despreader_corr #(.K(g)) u_corr (
      .i_win  (w_win_next),
      .o_dist (w_dist[g])
    );
  end

  // Strict '<' keeps the lowest index on ties
  always_comb begin
    w_min_dist = w_dist[0];
    w_min_idx  = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (w_dist[k] < w_min_dist) begin
        w_min_dist = w_dist[k];
        w_min_idx  = 4'(k);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_win        <= '0;
      r_fill       <= '0;
      r_chip_cnt   <= '0;
      r_bad_cnt    <= '0;
      r_state      <= S_SEARCH;
      r_enable_out <= 1'b0;
      r_symbol     <= '0;
      r_dist       <= '0;
    end else begin
      r_enable_out <= 1'b0;
      if (i_enable_in) begin
        r_win <= w_win_next;
        if (r_state == S_SEARCH) begin
          r_fill <= w_fill_next;
          if (w_fill_next == 6'd32 && w_dist[0] <= SYNC_T) begin
            r_state      <= S_LOCKED;
            r_chip_cnt   <= '0;
            r_bad_cnt    <= '0;
            r_enable_out <= 1'b1;
            r_symbol     <= 4'd0;
            r_dist       <= w_dist[0];
          end
        end else begin
          r_chip_cnt <= r_chip_cnt + 5'd1;
          if (r_chip_cnt == 5'd31) begin
            r_dist <= w_min_dist;
            if (w_min_dist <= DEC_T) begin
              r_enable_out <= 1'b1;
              r_symbol     <= w_min_idx;
              r_bad_cnt    <= '0;
            end else if (w_bad_next >= MAX_E) begin
              r_state   <= S_SEARCH;
              r_fill    <= '0;
              r_bad_cnt <= '0;
            end else begin
              r_bad_cnt <= w_bad_next;
            end
          end
        end
      end
    end
  end

  assign o_enable_out = r_enable_out;
  assign o_symbol     = r_symbol;
  assign o_locked     = (r_state == S_LOCKED);
`ifdef DESPREAD_DIST_EN
  assign o_distance   = r_dist;
`else
  logic w_unused_dist;
  assign w_unused_dist = ^r_dist;
`endif
endmodule
